approx_relu_pool: RTL and testbench

Downstream stage of the approximate convolution unit. Consumes the stream of 16-bit convolution results (one per `in_valid` cycle, raster order) and requantizes each to 8 bits with a right shift and saturation. It then performs 2x2, stride-2 max pooling and emits one 8-bit pooled pixel per 2x2 block. Its output feeds the next convolution layer's pixel input.

---
 rtl/approx_cnn_pkg.sv | 25 ++
 rtl/approx_pool_linebuf.sv | 24 ++
 rtl/approx_relu_pool.sv | 129 ++++++++++++
 tb/tb_approx_relu_pool.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_cnn_pkg.sv
// Shared widths, pooling phase encoding and requant helper
// for the approximate CNN datapath.
package approx_cnn_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {
    PH_EE = 2'b00,
    PH_EO = 2'b01,
    PH_OE = 2'b10,
    PH_OO = 2'b11
  } pool_phase_e;

  function automatic logic [DATA_W-1:0] sat_shift(
    input logic [ACC_W-1:0] v,
    input int unsigned      sh
  );
    logic [ACC_W-1:0] s;
    s = v >> sh;
    if (|s[ACC_W-1:DATA_W]) return '1;
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/approx_pool_linebuf.sv
// Half-row line buffer for 2x2 pooling: one write port,
// one combinational read port, contents not reset.
module approx_pool_linebuf #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/approx_relu_pool.sv
// Requantize conv results to OUT_W bits, then 2x2 stride-2
// max pooling over a raster stream.
module approx_relu_pool
  import approx_cnn_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = DATA_W,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LD = IMG_W / 2;
  localparam int AW = (LD > 1) ? $clog2(LD) : 1;
  localparam logic [IN_W-1:0] MAXV = IN_W'((1 << OUT_W) - 1);

  function automatic logic [OUT_W-1:0] max2(
    input logic [OUT_W-1:0] a,
    input logic [OUT_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]    col_q, col_d, col_e;
  logic [RW-1:0]    row_q, row_d, row_e;
  logic [OUT_W-1:0] hold_q, hold_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic [IN_W-1:0]  shifted;
  logic [OUT_W-1:0] q;
  pool_phase_e      phase;
  logic             lb_we;
  logic [AW-1:0]    lb_addr;
  logic [OUT_W-1:0] lb_wdata, lb_rdata;

  approx_pool_linebuf #(
    .DEPTH (LD),
    .W     (OUT_W),
    .AW    (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (lb_wdata),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_comb begin
    shifted = in_data >> SHIFT;
    q = shifted[OUT_W-1:0];
    if (shifted > MAXV) q = '1;

    // a qualified SOF forces this sample to (0,0)
    col_e = (in_valid && in_sof) ? '0 : col_q;
    row_e = (in_valid && in_sof) ? '0 : row_q;
    phase = pool_phase_e'({row_e[0], col_e[0]});

    lb_addr  = AW'(col_e >> 1);
    lb_wdata = max2(hold_q, q);
    lb_we    = 1'b0;

    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;

    if (in_valid) begin
      if (col_e == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_e == RW'(IMG_H - 1)) ? '0 : row_e + 1'b1;
      end else begin
        col_d = col_e + 1'b1;
        row_d = row_e;
      end

      unique case (phase)
        PH_EE: hold_d = q;
        PH_EO: lb_we  = 1'b1;
        PH_OE: hold_d = q;
        PH_OO: begin
          out_data_d  = max2(lb_rdata, max2(hold_q, q));
          out_valid_d = 1'b1;
          out_last_d  = (row_e == RW'(IMG_H - 1)) &&
                        (col_e == CW'(IMG_W - 1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_approx_relu_pool.sv
// Scoreboarded random/directed bench for approx_relu_pool
// against a frame-array reference model.
module tb_approx_relu_pool;

  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;

  approx_relu_pool #(
    .IN_W(16), .OUT_W(8), .IMG_W(W), .IMG_H(H), .SHIFT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int d;
    bit l;
    int c;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference model: requantized image plus raster position
  int img[H][W];
  int mr = 0;
  int mc = 0;

  function automatic int requant(input int d);
    int x;
    x = d / 16;
    if (x > 255) x = 255;
    return x;
  endfunction

  task automatic model_step(input int d, input bit sof, input int c);
    int m;
    exp_t e;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = requant(d);
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      m = img[mr][mc];
      if (img[mr][mc-1] > m) m = img[mr][mc-1];
      if (img[mr-1][mc] > m) m = img[mr-1][mc];
      if (img[mr-1][mc-1] > m) m = img[mr-1][mc-1];
      e.d = m;
      e.l = (mr == H-1) && (mc == W-1);
      e.c = c;
      sb.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  task automatic send(input int d, input bit sof);
    in_data  = 16'(d);
    in_sof   = sof;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    model_step(d, sof, cyc);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if ($urandom_range(1) == 1) in_sof = 1'b1;
      @(posedge clk);
      #1;
      in_sof = 1'b0;
    end
  endtask

  task automatic ramp(input bit sof, input int maxgap);
    for (int i = 0; i < W*H; i++) begin
      send(16*i, sof && i == 0);
      if (maxgap > 0) idle($urandom_range(maxgap));
    end
  endtask

  task automatic check(input string nm, input int act,
                       input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", int'(out_data), e.d);
        check("out_last", int'(out_last), int'(e.l));
        check("out_cycle", cyc, e.c);
      end
    end
    if (rst_n && out_last && !out_valid)
      check("last_without_valid", 1, 0);
  end

  task automatic reset_checks(input string nm);
    check({nm, "_valid"}, int'(out_valid), 0);
    check({nm, "_last"}, int'(out_last), 0);
    check({nm, "_data"}, int'(out_data), 0);
  endtask

  task automatic drain;
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      in_data  = 16'($urandom);
      in_valid = 1'($urandom);
      in_sof   = 1'($urandom);
      @(negedge clk);
      reset_checks("reset");
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    ramp(1'b1, 0);
    drain();

    for (int i = 0; i < W*H; i++) send(16'hFFFF, i == 0);
    for (int i = 0; i < W*H; i++) send(16'h0FF0, i == 0);
    for (int i = 0; i < W*H; i++) send(16'h0010, i == 0);
    drain();

    ramp(1'b1, 3);
    drain();

    for (int i = 0; i < 13; i++) send(16*i, i == 0);
    ramp(1'b1, 0);
    drain();

    for (int i = 0; i < W + 3; i++) send(16*i, i == 0);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_reset");
    mr = 0;
    mc = 0;
    @(negedge clk);
    reset_checks("mid_reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ramp(1'b0, 0);
    drain();

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W*H; i++) begin
        send(int'($urandom_range(16'hFFFF)), i == 0);
        if ($urandom_range(3) == 0) idle($urandom_range(2));
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
